reg_file_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32I core, the successor of the single-write, two-read register file. It adds configurable width, depth and port counts, same-cycle write-to-read bypass, a per-register busy scoreboard for the issue stage, and a post-reset clear sweep so the storage can map onto RAM-style arrays. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

---
 rtl/reg_file_mp.sv | 194 +++++++++++++++++++
 tb/tb_reg_file_mp.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Parametrised multi-port integer register file for the RV32I core.
//            Configurable width/depth/port counts, same-cycle write-to-read
//            bypass, per-register busy scoreboard for the issue stage and a
//            post-reset clear sweep so the storage needs no reset of its own.
// Ports    : clk        - clock, all state updates on posedge
//            reset_n    - synchronous active-low reset
//            rd_addr    - NRD read addresses, port i in slice i
//            rd_data    - NRD read results (combinational)
//            rd_busy    - NRD busy flags of the addressed registers (comb.)
//            wr_en      - NWR write strobes
//            wr_addr    - NWR write addresses
//            wr_data    - NWR write data words
//            iss_en     - mark iss_addr busy
//            iss_addr   - destination register being issued
//            init_done  - high once the clear sweep has finished
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 init_done
);

  // ptr carries one extra bit so the sweep counter never wraps back to 0
  localparam logic [AW:0] LAST_PTR = (AW+1)'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      ptr_q, ptr_d;
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic             ready;
  logic [NWR-1:0]   wr_ok;     // write strobes that really update storage
  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic             iss_ok;

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  // --------------------------------------------------------------------------
  // Write-port unpacking. A strobe is effective only in READY and never for
  // the hardwired zero register; everything downstream (storage, scoreboard,
  // bypass) keys off wr_ok so dropped writes are invisible everywhere.
  // --------------------------------------------------------------------------
  generate
    for (genvar j = 0; j < NWR; j++) begin : g_wr
      assign wa[j]    = wr_addr[j*AW +: AW];
      assign wd[j]    = wr_data[j*XLEN +: XLEN];
      assign wr_ok[j] = ready && wr_en[j] && !((ZERO_REG != 0) && (wa[j] == '0));
    end
  endgenerate

  assign iss_ok = ready && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // --------------------------------------------------------------------------
  // Sweep FSM: INIT walks ptr over every entry, then parks in READY.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + (AW+1)'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage next-state. Ports are applied in ascending order so that the
  // highest-index port wins on an address collision.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (!ready) begin
      mem_d[ptr_q[AW-1:0]] = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) begin
          mem_d[wa[j]] = wd[j];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard next-state. Clears are applied before the set so that an
  // issue to a register being written in the same cycle leaves it busy: the
  // newly issued instruction is the outstanding producer.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) begin
        busy_d[wa[j]] = 1'b0;
      end
    end
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset so it can map onto a RAM array; the sweep clears it.
  // Writes presented in a reset cycle are discarded.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      mem_q <= mem_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: storage, then optional bypass from this cycle's writes
  // (highest-index matching port last, so it takes priority), then the
  // zero-register and not-yet-initialised overrides.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] data;
      logic            busy;

      assign ra = rd_addr[i*AW +: AW];

      always_comb begin
        data = mem_q[ra];
        busy = busy_q[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j] && (wa[j] == ra)) begin
              data = wd[j];
              busy = 1'b0;
            end
          end
        end
        if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd_data[i*XLEN +: XLEN] = data;
      assign rd_busy[i]              = busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp. Main instance: 2 read /
//            2 write ports, ZERO_REG=1, BYPASS=1. Side instances cover
//            BYPASS=0 and ZERO_REG=0 with XLEN=16, NREGS=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // main instance
  logic [9:0]  m_rd_addr;  logic [63:0] m_rd_data;  logic [1:0] m_rd_busy;
  logic [1:0]  m_wr_en;    logic [9:0]  m_wr_addr;  logic [63:0] m_wr_data;
  logic        m_iss_en;   logic [4:0]  m_iss_addr; logic m_init_done;
  // no-bypass instance
  logic [4:0]  n_rd_addr;  logic [31:0] n_rd_data;  logic [0:0] n_rd_busy;
  logic [0:0]  n_wr_en;    logic [4:0]  n_wr_addr;  logic [31:0] n_wr_data;
  logic        n_iss_en;   logic [4:0]  n_iss_addr; logic n_init_done;
  // no-zero-register, 16x8 instance
  logic [2:0]  z_rd_addr;  logic [15:0] z_rd_data;  logic [0:0] z_rd_busy;
  logic [0:0]  z_wr_en;    logic [2:0]  z_wr_addr;  logic [15:0] z_wr_data;
  logic        z_iss_en;   logic [2:0]  z_iss_addr; logic z_init_done;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_main (
    .clk(clk), .reset_n(reset_n), .rd_addr(m_rd_addr), .rd_data(m_rd_data),
    .rd_busy(m_rd_busy), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
    .iss_en(m_iss_en), .iss_addr(m_iss_addr), .init_done(m_init_done));

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n), .rd_addr(n_rd_addr), .rd_data(n_rd_data),
    .rd_busy(n_rd_busy), .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
    .iss_en(n_iss_en), .iss_addr(n_iss_addr), .init_done(n_init_done));

  reg_file_mp #(.XLEN(16), .NREGS(8), .NRD(1), .NWR(1), .ZERO_REG(0), .BYPASS(1)) u_z (
    .clk(clk), .reset_n(reset_n), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .rd_busy(z_rd_busy), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .iss_en(z_iss_en), .iss_addr(z_iss_addr), .init_done(z_init_done));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model of the main instance ----------------
  logic [31:0] ref_mem [32];
  logic [31:0] ref_busy;
  bit          model_on;

  // Architectural view of a read: x0 is zero and idle; a same-cycle write
  // to the register is visible (last port wins) and shows it not busy.
  task automatic ref_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    d = ref_mem[a];
    b = ref_busy[a];
    for (int j = 0; j < 2; j++)
      if (m_wr_en[j] && m_wr_addr[j*5 +: 5] == a) begin
        d = m_wr_data[j*32 +: 32];
        b = 1'b0;
      end
    if (a == 5'd0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge with the present inputs.
  task automatic model_commit();
    if (!reset_n) begin
      model_on = 1'b0;
      ref_busy = '0;
    end else if (model_on) begin
      for (int j = 0; j < 2; j++)
        if (m_wr_en[j] && m_wr_addr[j*5 +: 5] != 5'd0) begin
          ref_mem[m_wr_addr[j*5 +: 5]]  = m_wr_data[j*32 +: 32];
          ref_busy[m_wr_addr[j*5 +: 5]] = 1'b0;
        end
      if (m_iss_en && m_iss_addr != 5'd0) ref_busy[m_iss_addr] = 1'b1;
    end
  endtask

  // One clock: model sees the edge, then we land on the next negedge.
  task automatic tick();
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_main();
    m_rd_addr = '0; m_wr_en = '0; m_wr_addr = '0; m_wr_data = '0;
    m_iss_en = 1'b0; m_iss_addr = '0;
  endtask

  task automatic idle_all();
    idle_main();
    n_rd_addr = '0; n_wr_en = '0; n_wr_addr = '0; n_wr_data = '0; n_iss_en = 1'b0; n_iss_addr = '0;
    z_rd_addr = '0; z_wr_en = '0; z_wr_addr = '0; z_wr_data = '0; z_iss_en = 1'b0; z_iss_addr = '0;
  endtask

  // Runs the clear sweep with junk writes/issues presented throughout and
  // counts cycles until init_done; reads must stay zero and idle meanwhile.
  task automatic sweep(output int n);
    n = 0;
    m_wr_en = 2'b11; m_wr_addr = {5'd6, 5'd3}; m_wr_data = {32'h0000_0066, 32'hFFFF_0000};
    m_iss_en = 1'b1; m_iss_addr = 5'd6; m_rd_addr = {5'd6, 5'd3};
    #1;
    while (!m_init_done && n < 64) begin
      chk("init_rd_data", m_rd_data, 64'd0);
      chk("init_rd_busy", m_rd_busy, 64'd0);
      tick(); #1;
      n++;
    end
    idle_main();
    for (int r = 0; r < 32; r++) ref_mem[r] = '0;
    ref_busy = '0;
    model_on = 1'b1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic        iss; logic [4:0]  ia;
    logic [4:0]  ra0; logic [4:0]  ra1;
    logic [31:0] e0;  logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    int n;
    logic [31:0] d;
    logic        b;

    // Each row is one cycle from a freshly cleared file; expectations are
    // the same-cycle read results.
    tbl[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
    tbl[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        2'b00};
    tbl[2]  = '{2'b11, 5'd7,  32'h11111111, 5'd7,  32'h22222222, 1'b0, 5'd0,  5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF, 2'b00};
    tbl[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  32'h22222222, 32'h0,        2'b00};
    tbl[4]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00};
    tbl[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd0,  5'd9,  32'h0,        32'h0,        2'b00};
    tbl[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11};
    tbl[7]  = '{2'b01, 5'd9,  32'h5,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd5,  32'h5,        32'hDEADBEEF, 2'b00};
    tbl[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0,  5'd9,  5'd0,  32'h5,        32'h0,        2'b01};
    tbl[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'h5,        2'b10};
    tbl[10] = '{2'b10, 5'd0,  32'h0,        5'd9,  32'h77,       1'b0, 5'd0,  5'd9,  5'd7,  32'h77,       32'h22222222, 2'b00};
    tbl[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd3,  32'h77,       32'h0,        2'b00};
    tbl[12] = '{2'b11, 5'd12, 32'hAAAA0001, 5'd13, 32'hBBBB0002, 1'b0, 5'd0,  5'd13, 5'd12, 32'hBBBB0002, 32'hAAAA0001, 2'b00};
    tbl[13] = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 5'd12, 5'd12, 5'd13, 32'hAAAA0001, 32'hBBBB0002, 2'b00};
    tbl[14] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd0,  32'hAAAA0001, 32'h0,        2'b01};

    // ---------------- reset state ----------------
    model_on = 1'b0;
    ref_busy = '0;
    reset_n  = 1'b0;
    idle_all();
    m_rd_addr = {5'd3, 5'd5};
    @(negedge clk); @(negedge clk); #1;
    chk("rst_init_done", m_init_done, 64'd0);
    chk("rst_rd_data",   m_rd_data,   64'd0);
    chk("rst_rd_busy",   m_rd_busy,   64'd0);
    chk("rst_nb_done",   n_init_done, 64'd0);
    chk("rst_z_done",    z_init_done, 64'd0);

    // ---------------- clear sweep ----------------
    reset_n = 1'b1;
    sweep(n);
    chk("sweep_cycles", n, 64'd32);
    chk("nb_done", n_init_done, 64'd1);
    chk("z_done",  z_init_done, 64'd1);

    // ---------------- vector table ----------------
    for (int k = 0; k < NV; k++) begin
      tick();
      m_wr_en    = tbl[k].we;
      m_wr_addr  = {tbl[k].wa1, tbl[k].wa0};
      m_wr_data  = {tbl[k].wd1, tbl[k].wd0};
      m_iss_en   = tbl[k].iss;
      m_iss_addr = tbl[k].ia;
      m_rd_addr  = {tbl[k].ra1, tbl[k].ra0};
      #1;
      chk($sformatf("vec%0d_data0", k), m_rd_data[31:0],  tbl[k].e0);
      chk($sformatf("vec%0d_data1", k), m_rd_data[63:32], tbl[k].e1);
      chk($sformatf("vec%0d_busy", k),  m_rd_busy,        tbl[k].eb);
    end
    tick(); idle_main();

    // ---------------- BYPASS=0 instance ----------------
    n_wr_en = 1'b1; n_wr_addr = 5'd5; n_wr_data = 32'hDEADBEEF; n_rd_addr = 5'd5; #1;
    chk("nb_same_cycle", n_rd_data, 64'd0);
    tick();
    n_wr_en = 1'b0; n_iss_en = 1'b1; n_iss_addr = 5'd9; #1;
    chk("nb_next_cycle", n_rd_data, 64'hDEADBEEF);
    tick();
    n_iss_en = 1'b0; n_wr_en = 1'b1; n_wr_addr = 5'd9; n_wr_data = 32'h5; n_rd_addr = 5'd9; #1;
    chk("nb_busy_held", n_rd_busy, 64'd1);
    chk("nb_old_data",  n_rd_data, 64'd0);
    tick();
    n_wr_en = 1'b0; #1;
    chk("nb_busy_clr", n_rd_busy, 64'd0);
    chk("nb_new_data", n_rd_data, 64'h5);

    // ---------------- ZERO_REG=0, 16-bit, 8 entries ----------------
    tick();
    z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 16'h1234; z_rd_addr = 3'd0; #1;
    chk("z_x0_bypass", z_rd_data, 64'h1234);
    tick();
    z_wr_en = 1'b0; z_iss_en = 1'b1; z_iss_addr = 3'd0; #1;
    chk("z_x0_stored", z_rd_data, 64'h1234);
    chk("z_x0_idle",   z_rd_busy, 64'd0);
    tick();
    z_iss_en = 1'b0; #1;
    chk("z_x0_busy", z_rd_busy, 64'd1);

    // ---------------- randomized against the model ----------------
    for (int c = 0; c < 400; c++) begin
      tick();
      m_wr_en    = 2'($urandom_range(0, 3));
      m_wr_addr  = {rnd_addr(), rnd_addr()};
      m_wr_data  = {$urandom, $urandom};
      m_iss_en   = 1'($urandom_range(0, 1));
      m_iss_addr = rnd_addr();
      m_rd_addr  = {rnd_addr(), rnd_addr()};
      #1;
      for (int i = 0; i < 2; i++) begin
        ref_read(m_rd_addr[i*5 +: 5], d, b);
        chk($sformatf("rnd%0d_data%0d", c, i), m_rd_data[i*32 +: 32], d);
        chk($sformatf("rnd%0d_busy%0d", c, i), m_rd_busy[i], b);
      end
    end

    // ---------------- reset while READY ----------------
    tick(); idle_main();
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd3}; m_wr_data = {32'h0, 32'hA5A5A5A5};
    tick(); idle_main();
    m_rd_addr = {5'd0, 5'd3}; #1;
    chk("x3_written", m_rd_data[31:0], 64'hA5A5A5A5);
    tick();
    reset_n = 1'b0;
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd4}; m_wr_data = {32'h0, 32'h1};
    m_iss_en = 1'b1; m_iss_addr = 5'd4;
    tick();
    reset_n = 1'b1; idle_main(); #1;
    chk("rerst_init_done", m_init_done, 64'd0);
    sweep(n);
    chk("resweep_cycles", n, 64'd32);
    for (int a = 0; a < 32; a += 2) begin
      tick();
      m_rd_addr = {5'(a + 1), 5'(a)}; #1;
      chk($sformatf("clr_data_x%0d", a), m_rd_data, 64'd0);
      chk($sformatf("clr_busy_x%0d", a), m_rd_busy, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
